// File: rtl/opener.sv
// Garage door opener controller: 4-state Moore FSM driving motor up/down.
// While r_n is low the state is forced to a value derived from the limit
// switches (closed -> Closed, else open -> Open, else Opening) and follows
// those switches live.
// Optional feature macro: OPENER_BTN_REVERSE_EN -- when defined, pressing the
// button while Closing reverses the door, with the same priority as the
// obstacle sensor.
module opener (
  input  logic       clk,
  input  logic       r_n,
  input  logic       b,
  input  logic       c,
  input  logic       o,
  input  logic       s,
  output logic       d,
  output logic       u,
  output logic [1:0] State
);

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    CLOSED  = 2'b00,
    OPENING = 2'b01,
    OPEN    = 2'b10,
    CLOSING = 2'b11
  } state_t;

  state_t r_state;
  state_t w_rst_state;
  state_t w_cur;
  state_t w_next;
  logic   r_rst_q;
  logic   w_rev;

  // Position-derived reset value; closed switch wins over open switch.
  always_comb begin
    w_rst_state = OPENING;
    if (c) begin
      w_rst_state = CLOSED;
    end else if (o) begin
      w_rst_state = OPEN;
    end
  end

  // Reset-window flag: set asynchronously by reset, cleared by the first
  // clock edge after release. While set, the live position value stands in
  // for the state register, so the state follows c/o during reset and the
  // first post-reset edge transitions from exactly what was presented.
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      r_rst_q <= 1'b1;
    end else begin
      r_rst_q <= 1'b0;
    end
  end

  assign w_cur = r_rst_q ? w_rst_state : r_state;

`ifdef OPENER_BTN_REVERSE_EN
  assign w_rev = s | b;
`else
  assign w_rev = s;
`endif

  // State register.
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      r_state <= CLOSED;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; b is level-sensitive.
  always_comb begin
    w_next = w_cur;
    case (w_cur)
      CLOSED: begin
        if (b) w_next = OPENING;
      end
      OPENING: begin
        if (o) w_next = OPEN;
      end
      OPEN: begin
        if (b && !s) w_next = CLOSING;
      end
      CLOSING: begin
        if (w_rev) begin
          w_next = OPENING;
        end else if (c) begin
          w_next = CLOSED;
        end
      end
      default: w_next = w_cur;
    endcase
  end

  // Moore outputs decoded from the current state only.
  assign State = w_cur;
  assign u     = (w_cur == OPENING);
  assign d     = (w_cur == CLOSING);

endmodule

// File: tb/tb_opener.sv
// Scoreboard bench for opener: stimulus pushes expected state/outputs,
// a negedge monitor pops and compares.
module tb_opener;

  logic       clk;
  logic       r_n;
  logic       b;
  logic       c;
  logic       o;
  logic       s;
  logic       d;
  logic       u;
  logic [1:0] State;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic       eu;
    logic       ed;
  } exp_t;

  exp_t q[$];
  int   n_tests;
  int   n_fail;

  localparam logic [1:0] ST_CLOSED  = 2'b00;
  localparam logic [1:0] ST_OPENING = 2'b01;
  localparam logic [1:0] ST_OPEN    = 2'b10;
  localparam logic [1:0] ST_CLOSING = 2'b11;

  opener dut (
    .clk   (clk),
    .r_n   (r_n),
    .b     (b),
    .c     (c),
    .o     (o),
    .s     (s),
    .d     (d),
    .u     (u),
    .State (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs just after a falling edge, then queue the expectation
  // for the state seen after the following rising edge.
  task automatic cyc(input string name, input logic rn, input logic bi,
                     input logic ci, input logic oi, input logic si,
                     input logic [1:0] est, input logic eu, input logic ed);
    exp_t e;
    @(negedge clk);
    #1;
    r_n = rn; b = bi; c = ci; o = oi; s = si;
    @(posedge clk);
    #1;
    e.name = name; e.st = est; e.eu = eu; e.ed = ed;
    q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_tests++;
      if (State !== e.st || u !== e.eu || d !== e.ed) begin
        n_fail++;
        $display("FAIL %s: got State=%b u=%b d=%b, expected State=%b u=%b d=%b",
                 e.name, State, u, d, e.st, e.eu, e.ed);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    r_n = 1'b0; b = 1'b0; c = 1'b0; o = 1'b0; s = 1'b0;

    // Reset values from position switches
    cyc("rst_mid",        0, 0, 0, 0, 0, ST_OPENING, 1, 0);
    cyc("rst_open",       0, 0, 0, 1, 0, ST_OPEN,    0, 0);
    cyc("rst_both_prio",  0, 0, 1, 1, 0, ST_CLOSED,  0, 0);
    cyc("rst_closed",     0, 0, 1, 0, 0, ST_CLOSED,  0, 0);
    cyc("release_closed", 1, 0, 1, 0, 0, ST_CLOSED,  0, 0);

    // Closed ignores s, c, o
    cyc("closed_ign_s",   1, 0, 1, 0, 1, ST_CLOSED,  0, 0);
    cyc("closed_ign_os",  1, 0, 0, 1, 1, ST_CLOSED,  0, 0);

    // Full cycle with ignored inputs while Opening
    cyc("closed_to_open", 1, 1, 1, 0, 0, ST_OPENING, 1, 0);
    cyc("opening_ign_bc", 1, 1, 1, 0, 0, ST_OPENING, 1, 0);
    cyc("opening_ign_s",  1, 1, 0, 0, 1, ST_OPENING, 1, 0);
    cyc("opening_to_open",1, 0, 0, 1, 0, ST_OPEN,    0, 0);
    cyc("open_blocked1",  1, 1, 0, 1, 1, ST_OPEN,    0, 0);
    cyc("open_blocked2",  1, 1, 0, 1, 1, ST_OPEN,    0, 0);
    cyc("open_idle",      1, 0, 0, 1, 0, ST_OPEN,    0, 0);
    cyc("open_to_closing",1, 1, 0, 1, 0, ST_CLOSING, 0, 1);
    cyc("closing_hold",   1, 0, 0, 0, 0, ST_CLOSING, 0, 1);
    cyc("closing_to_cl",  1, 0, 1, 0, 0, ST_CLOSED,  0, 0);

    // Obstacle reversal
    cyc("cyc2_opening",   1, 1, 1, 0, 0, ST_OPENING, 1, 0);
    cyc("cyc2_open",      1, 0, 0, 1, 0, ST_OPEN,    0, 0);
    cyc("cyc2_closing",   1, 1, 0, 1, 0, ST_CLOSING, 0, 1);
    cyc("obstacle_rev",   1, 0, 0, 0, 1, ST_OPENING, 1, 0);
    cyc("cyc3_open",      1, 0, 0, 1, 0, ST_OPEN,    0, 0);
    cyc("cyc3_closing",   1, 1, 0, 1, 0, ST_CLOSING, 0, 1);
    cyc("obst_and_closed",1, 0, 1, 0, 1, ST_OPENING, 1, 0);

    // Button while Closing: reversal only with the feature enabled
    cyc("cyc4_open",      1, 0, 0, 1, 0, ST_OPEN,    0, 0);
    cyc("cyc4_closing",   1, 1, 0, 1, 0, ST_CLOSING, 0, 1);
`ifdef OPENER_BTN_REVERSE_EN
    cyc("closing_btn",    1, 1, 0, 0, 0, ST_OPENING, 1, 0);
`else
    cyc("closing_btn",    1, 1, 0, 0, 0, ST_CLOSING, 0, 1);
`endif

    // Mid-travel reset and tracking of switches while held in reset
    cyc("midtravel_rst",  0, 0, 0, 0, 0, ST_OPENING, 1, 0);
    cyc("rst_track_c",    0, 0, 1, 0, 0, ST_CLOSED,  0, 0);
    cyc("rst_track_o",    0, 0, 0, 1, 0, ST_OPEN,    0, 0);
    cyc("release_open",   1, 0, 0, 1, 0, ST_OPEN,    0, 0);
    cyc("post_rst_close", 1, 1, 0, 1, 0, ST_CLOSING, 0, 1);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
